// File: rtl/ddr4_cmd_responder.sv
`default_nettype none
// ddr4_cmd_responder: DDR4 device-side command decoder, per-bank row tracker and burst data model.
// Define TIMING_CHECK_EN to add per-bank tRCD checking reported on err[5].
module ddr4_cmd_responder #(
   parameter int DQ_WIDTH     = 8,
   parameter int ROW_BITS     = 4,
   parameter int COL_BITS     = 6,
   parameter int BURST_LENGTH = 8,
   parameter int CL           = 11,
   parameter int CWL          = 9,
   parameter int TRCD         = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cke,
   input  logic                cs_n,
   input  logic                act_n,
   input  logic [15:0]         adr,
   input  logic [1:0]          ba,
   input  logic                bg,
   input  logic [DQ_WIDTH-1:0] wr_data,
   input  logic                wr_data_valid,
   output logic [DQ_WIDTH-1:0] rd_data,
   output logic                rd_valid,
   output logic [7:0]          open_banks,
   output logic [15:0]         ref_count,
`ifdef TIMING_CHECK_EN
   output logic [5:0]          err,
`else
   output logic [4:0]          err,
`endif
   input  logic                err_clear
);

   localparam int ERR_W  = $bits(err);
   localparam int ADDR_W = 3 + ROW_BITS + COL_BITS;
   localparam int DEPTH  = 1 << ADDR_W;

   logic [DQ_WIDTH-1:0] mem [DEPTH];
   logic [ROW_BITS-1:0] open_row [8];

   logic [15:0] now, bus_free;
   logic [3:0]  q_valid;
   logic [1:0]  wr_ptr, rd_ptr;
   logic        q_wr    [4];
   logic [2:0]  q_bank  [4];
   logic [ROW_BITS-1:0] q_row [4];
   logic [COL_BITS-1:0] q_col [4];
   logic [15:0] q_start [4];

   logic        cmd_en, is_act, is_pre, is_ref, is_wr, is_rd, rw_cmd;
   logic [2:0]  bank;
   logic        bank_open, collide, rw_accept, bus_stale, pop;
   logic [15:0] win_start, win_diff, stale_diff, head_beat;
   logic [COL_BITS-1:0] col_base;
   logic        rd_hit, wr_hit;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [ERR_W-1:0]  new_err;
   logic        unused_adr;

   assign cmd_en    = cke && !cs_n;
   assign bank      = {bg, ba};
   assign is_act    = cmd_en && !act_n;
   assign is_pre    = cmd_en && act_n && (adr[15:13] == 3'b010);
   assign is_ref    = cmd_en && act_n && (adr[15:13] == 3'b001);
   assign is_wr     = cmd_en && act_n && (adr[15:13] == 3'b100);
   assign is_rd     = cmd_en && act_n && (adr[15:13] == 3'b101);
   assign rw_cmd    = is_rd || is_wr;
   assign bank_open = open_banks[bank];
   assign col_base  = adr[COL_BITS-1:0] & ~COL_BITS'(BURST_LENGTH - 1);
   assign unused_adr = ^adr;

   // Window ordering uses wrap-safe signed differences on the free-running timestamp.
   assign win_start  = now + (is_rd ? 16'(CL) : 16'(CWL));
   assign win_diff   = win_start - bus_free;
   assign collide    = win_diff[15];
   assign stale_diff = bus_free - now;
   assign bus_stale  = stale_diff[15];
   assign rw_accept  = rw_cmd && bank_open && !collide;

   // Read entries start one cycle early so data is registered out of the array on time.
   always_comb begin
      rd_hit  = 1'b0;
      wr_hit  = 1'b0;
      rd_addr = '0;
      wr_addr = '0;
      for (int i = 0; i < 4; i++) begin
         logic [15:0] beat;
         beat = now - q_start[i];
         if (q_valid[i] && (beat < 16'(BURST_LENGTH))) begin
            if (q_wr[i]) begin
               wr_hit  = 1'b1;
               wr_addr = {q_bank[i], q_row[i], q_col[i] + COL_BITS'(beat)};
            end else begin
               rd_hit  = 1'b1;
               rd_addr = {q_bank[i], q_row[i], q_col[i] + COL_BITS'(beat)};
            end
         end
      end
   end

   assign head_beat = now - q_start[rd_ptr];
   assign pop       = q_valid[rd_ptr] && (head_beat == 16'(BURST_LENGTH - 1));

`ifdef TIMING_CHECK_EN
   localparam int TCW = $clog2(TRCD + 2);
   logic [TCW-1:0] trcd_cnt [8];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 8; b++) trcd_cnt[b] <= '0;
      end else begin
         for (int b = 0; b < 8; b++) begin
            if (is_act && !bank_open && (bank == 3'(b)))
               trcd_cnt[b] <= TCW'(TRCD);
            else if (trcd_cnt[b] != '0)
               trcd_cnt[b] <= trcd_cnt[b] - 1'b1;
         end
      end
   end

   assign new_err[5] = rw_cmd && (trcd_cnt[bank] != '0);
`endif

   assign new_err[0] = rw_cmd && !bank_open;
   assign new_err[1] = is_act && bank_open;
   assign new_err[2] = is_ref && (open_banks != 8'h00);
   assign new_err[3] = rw_cmd && bank_open && collide;
   assign new_err[4] = wr_hit && !wr_data_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         now        <= '0;
         bus_free   <= '0;
         open_banks <= '0;
         ref_count  <= '0;
         err        <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         q_valid    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         now      <= now + 16'd1;
         rd_valid <= rd_hit;
         rd_data  <= rd_hit ? mem[rd_addr] : '0;
         err      <= (err_clear ? '0 : err) | new_err;

         if (rw_accept)
            bus_free <= win_start + 16'(BURST_LENGTH);
         else if (bus_stale)
            bus_free <= now;

         if (is_act && !bank_open)
            open_banks[bank] <= 1'b1;
         if (is_pre)
            open_banks <= adr[10] ? 8'h00 : (open_banks & ~(8'b1 << bank));
         if (rw_accept && adr[10])
            open_banks[bank] <= 1'b0;

         if (is_ref && (open_banks == 8'h00))
            ref_count <= ref_count + 16'd1;

         if (pop) begin
            q_valid[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + 2'd1;
         end
         if (rw_accept) begin
            q_valid[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + 2'd1;
         end
      end
   end

   // Payload storage carries no reset; validity lives in q_valid/open_banks.
   always_ff @(posedge clk) begin
      if (is_act && !bank_open)
         open_row[bank] <= adr[ROW_BITS-1:0];
      if (rw_accept) begin
         q_wr[wr_ptr]    <= is_wr;
         q_bank[wr_ptr]  <= bank;
         q_row[wr_ptr]   <= open_row[bank];
         q_col[wr_ptr]   <= col_base;
         q_start[wr_ptr] <= is_rd ? (win_start - 16'd1) : win_start;
      end
      if (wr_hit && wr_data_valid)
         mem[wr_addr] <= wr_data;
   end

endmodule
`default_nettype wire

// File: tb/tb_ddr4_cmd_responder.sv
`timescale 1ns/1ps
`default_nettype none
// tb_ddr4_cmd_responder: directed self-checking bench for ddr4_cmd_responder.
module tb_ddr4_cmd_responder;
`ifdef TIMING_CHECK_EN
   localparam int EW = 6;
`else
   localparam int EW = 5;
`endif
   localparam int K_ACT = 0, K_PRE = 1, K_REF = 2, K_WR = 3, K_RD = 4;

   logic clk = 1'b0;
   logic reset, cke, cs_n, act_n, bg, wr_data_valid, err_clear, rd_valid;
   logic [15:0] adr, ref_count;
   logic [1:0]  ba;
   logic [7:0]  wr_data, rd_data, open_banks;
   logic [EW-1:0] err;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ddr4_cmd_responder dut (
      .clk(clk), .reset(reset), .cke(cke), .cs_n(cs_n), .act_n(act_n), .adr(adr),
      .ba(ba), .bg(bg), .wr_data(wr_data), .wr_data_valid(wr_data_valid),
      .rd_data(rd_data), .rd_valid(rd_valid), .open_banks(open_banks),
      .ref_count(ref_count), .err(err), .err_clear(err_clear)
   );

   task automatic tick();
      @(negedge clk);
      cs_n = 1'b1; act_n = 1'b1; adr = 16'h0000; err_clear = 1'b0;
   endtask

   task automatic drive_cmd(input int kind, input logic [2:0] b, input logic [15:0] a);
      cs_n = 1'b0; {bg, ba} = b; act_n = 1'b1;
      case (kind)
         K_ACT:   begin act_n = 1'b0; adr = a; end
         K_PRE:   adr = {3'b010, a[12:0]};
         K_REF:   adr = {3'b001, a[12:0]};
         K_WR:    adr = {3'b100, a[12:0]};
         default: adr = {3'b101, a[12:0]};
      endcase
   endtask

   task automatic test_reset();
      reset = 1'b1; cke = 1'b1; cs_n = 1'b1; act_n = 1'b1; adr = '0; ba = '0; bg = 1'b0;
      wr_data = '0; wr_data_valid = 1'b0; err_clear = 1'b0;
      tick(); tick();
      tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
      tests++; if (rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
      tests++; if (open_banks !== 8'h00) begin fails++; $display("FAIL reset_open_banks: got %h want 00", open_banks); end
      tests++; if (ref_count !== 16'h0000) begin fails++; $display("FAIL reset_ref_count: got %h want 0000", ref_count); end
      tests++; if (err !== '0) begin fails++; $display("FAIL reset_err: got %h want 0", err); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      logic [7:0] exp;
      drive_cmd(K_ACT, 3'd3, 16'd5); tick();
      tests++; if (open_banks !== 8'h08) begin fails++; $display("FAIL wr_rd_act: got %h want 08", open_banks); end
      for (int j = 0; j <= 40; j++) begin
         tests++;
         if (rd_valid !== (j >= 31 && j <= 38)) begin
            fails++; $display("FAIL wr_rd_valid cycle %0d: got %b want %b", j, rd_valid, (j >= 31 && j <= 38));
         end
         if (j >= 31 && j <= 38) begin
            exp = 8'hA0 + 8'(j - 31);
            tests++; if (rd_data !== exp) begin fails++; $display("FAIL wr_rd_data cycle %0d: got %h want %h", j, rd_data, exp); end
         end
         wr_data_valid = (j >= 9 && j <= 16);
         wr_data = 8'hA0 + 8'(j - 9);
         if (j == 0)  drive_cmd(K_WR, 3'd3, 16'h0010);
         if (j == 20) drive_cmd(K_RD, 3'd3, 16'h0010);
         tick();
      end
      wr_data_valid = 1'b0;
      tests++; if (err !== '0) begin fails++; $display("FAIL wr_rd_err: got %h want 0", err); end
   endtask

   task automatic test_closed_bank();
      int seen = 0;
      drive_cmd(K_RD, 3'd2, 16'h0000); tick();
      for (int j = 0; j < 20; j++) begin
         if (rd_valid === 1'b1) seen++;
         tick();
      end
      tests++; if (seen != 0) begin fails++; $display("FAIL closed_rd_valid: got %0d beats want 0", seen); end
      tests++; if (err !== EW'(5'h01)) begin fails++; $display("FAIL closed_err: got %h want 01", err); end
      err_clear = 1'b1; tick();
      tests++; if (err !== '0) begin fails++; $display("FAIL closed_err_clear: got %h want 0", err); end
   endtask

   task automatic test_act_ref();
      drive_cmd(K_ACT, 3'd1, 16'd0); tick();
      drive_cmd(K_ACT, 3'd1, 16'd2); tick();
      tests++; if (err !== EW'(5'h02)) begin fails++; $display("FAIL act_open_err: got %h want 02", err); end
      tests++; if (open_banks !== 8'h0A) begin fails++; $display("FAIL act_open_banks: got %h want 0a", open_banks); end
      drive_cmd(K_REF, 3'd0, 16'h0000); err_clear = 1'b1; tick();
      tests++; if (err !== EW'(5'h04)) begin fails++; $display("FAIL clear_vs_new_err: got %h want 04", err); end
      tests++; if (ref_count !== 16'd0) begin fails++; $display("FAIL ref_blocked_count: got %0d want 0", ref_count); end
      drive_cmd(K_PRE, 3'd2, 16'h0000); tick();
      tests++; if (open_banks !== 8'h0A || err !== EW'(5'h04)) begin
         fails++; $display("FAIL pre_closed: got banks %h err %h want 0a 04", open_banks, err);
      end
      drive_cmd(K_PRE, 3'd0, 16'h0400); tick();
      tests++; if (open_banks !== 8'h00) begin fails++; $display("FAIL prea: got %h want 00", open_banks); end
      err_clear = 1'b1; tick();
      drive_cmd(K_REF, 3'd0, 16'h0000); tick();
      drive_cmd(K_REF, 3'd0, 16'h0000); tick();
      tests++; if (ref_count !== 16'd2) begin fails++; $display("FAIL ref_count: got %0d want 2", ref_count); end
      drive_cmd(K_ACT, 3'd4, 16'd0); tick();
      drive_cmd(K_REF, 3'd0, 16'h0000); tick();
      tests++; if (err !== EW'(5'h04)) begin fails++; $display("FAIL ref_open_err: got %h want 04", err); end
      tests++; if (ref_count !== 16'd2) begin fails++; $display("FAIL ref_open_count: got %0d want 2", ref_count); end
      drive_cmd(K_PRE, 3'd0, 16'h0400); err_clear = 1'b1; tick();
      tests++; if (err !== '0 || open_banks !== 8'h00) begin
         fails++; $display("FAIL act_ref_cleanup: got err %h banks %h want 0 00", err, open_banks);
      end
   endtask

   task automatic test_back_to_back();
      drive_cmd(K_ACT, 3'd0, 16'd1); tick();
      for (int j = 0; j <= 40; j++) begin
         tests++;
         if (rd_valid !== (j >= 11 && j <= 26)) begin
            fails++; $display("FAIL b2b_rd_valid cycle %0d: got %b want %b", j, rd_valid, (j >= 11 && j <= 26));
         end
         if (j == 0 || j == 4 || j == 8) drive_cmd(K_RD, 3'd0, 16'h0000);
         tick();
      end
      tests++; if (err !== EW'(5'h08)) begin fails++; $display("FAIL b2b_collision_err: got %h want 08", err); end
      err_clear = 1'b1; tick();
   endtask

   task automatic test_missing_beat();
      logic [7:0] exp;
      for (int j = 0; j <= 40; j++) begin
         if (j >= 31 && j <= 38) begin
            exp = (j - 31 == 3) ? 8'h13 : 8'h50 + 8'(j - 31);
            tests++; if (rd_valid !== 1'b1 || rd_data !== exp) begin
               fails++; $display("FAIL miss_beat_data cycle %0d: got %b/%h want 1/%h", j, rd_valid, rd_data, exp);
            end
         end
         wr_data_valid = 1'b0;
         if (j >= 9 && j <= 16) begin wr_data_valid = 1'b1; wr_data = 8'h10 + 8'(j - 9); end
         if (j >= 17 && j <= 24) begin wr_data_valid = (j - 17 != 3); wr_data = 8'h50 + 8'(j - 17); end
         if (j == 0 || j == 8) drive_cmd(K_WR, 3'd0, 16'h0020);
         if (j == 20) drive_cmd(K_RD, 3'd0, 16'h0020);
         tick();
      end
      wr_data_valid = 1'b0;
      tests++; if (err !== EW'(5'h10)) begin fails++; $display("FAIL miss_beat_err: got %h want 10", err); end
      err_clear = 1'b1; tick();
   endtask

   task automatic test_auto_precharge();
      logic [7:0] exp;
      for (int j = 0; j <= 20; j++) begin
         if (j == 1) begin
            tests++; if (open_banks !== 8'h00) begin fails++; $display("FAIL ap_close: got %h want 00", open_banks); end
         end
         if (j == 2) begin
            tests++; if (open_banks !== 8'h01) begin fails++; $display("FAIL ap_reopen: got %h want 01", open_banks); end
         end
         if (j >= 11 && j <= 18) begin
            exp = (j - 11 == 3) ? 8'h13 : 8'h50 + 8'(j - 11);
            tests++; if (rd_valid !== 1'b1 || rd_data !== exp) begin
               fails++; $display("FAIL ap_data cycle %0d: got %b/%h want 1/%h", j, rd_valid, rd_data, exp);
            end
         end
         if (j == 0) drive_cmd(K_RD, 3'd0, 16'h0423);
         if (j == 1) drive_cmd(K_ACT, 3'd0, 16'd7);
         tick();
      end
      tests++; if (err !== '0) begin fails++; $display("FAIL ap_err: got %h want 0", err); end
      drive_cmd(K_PRE, 3'd0, 16'h0400); tick();
   endtask

`ifdef TIMING_CHECK_EN
   task automatic test_trcd();
      drive_cmd(K_ACT, 3'd5, 16'd0); tick();
      tick();
      drive_cmd(K_RD, 3'd5, 16'h0000); tick();
      tests++; if (err !== 6'h20) begin fails++; $display("FAIL trcd_err: got %h want 20", err); end
      repeat (25) tick();
      drive_cmd(K_PRE, 3'd0, 16'h0400); err_clear = 1'b1; tick();
   endtask
`endif

   task automatic test_reset_mid_burst();
      int seen = 0;
      drive_cmd(K_ACT, 3'd7, 16'd0); tick();
      drive_cmd(K_RD, 3'd7, 16'h0000); tick();
      repeat (11) tick();
      tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL mid_burst_active: got %b want 1", rd_valid); end
      reset = 1'b1;
      #1;
      tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL mid_burst_reset_valid: got %b want 0", rd_valid); end
      tests++; if (open_banks !== 8'h00) begin fails++; $display("FAIL mid_burst_reset_banks: got %h want 00", open_banks); end
      tick();
      reset = 1'b0;
      for (int j = 0; j < 15; j++) begin
         if (rd_valid === 1'b1) seen++;
         tick();
      end
      tests++; if (seen != 0) begin fails++; $display("FAIL mid_burst_discard: got %0d beats want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_closed_bank();
      test_act_ref();
      test_back_to_back();
      test_missing_beat();
      test_auto_precharge();
`ifdef TIMING_CHECK_EN
      test_trcd();
`endif
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
